// File: rtl/riscv_v_wb_seq_pkg.sv
// Shared constants, state type and helpers for the vector RF write sequencer.
// The optional tail-agnostic fill is enabled by defining RISCV_V_WB_VTA_EN.
package riscv_v_wb_seq_pkg;

   localparam int DATA_W           = 128;
   localparam int NUM_BYTES        = DATA_W / 8;
   localparam int BYTE_IDX_W       = $clog2(NUM_BYTES);
   localparam int ADDR_W           = 5;
   localparam int RISCV_V_MAX_VLEN = 128;
   localparam int RISCV_V_WB_VL_W  = $clog2(RISCV_V_MAX_VLEN) + 1;
   localparam int VL_W             = RISCV_V_WB_VL_W;
   localparam int RISCV_V_MAX_LMUL = 8;
   localparam int CNT_W            = $clog2(RISCV_V_MAX_LMUL);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } riscv_v_wb_state_e;

   // Index of the final beat of a group: 2**vlmul registers, minus one.
   function automatic logic [CNT_W-1:0] last_beat(input logic [1:0] vlmul);
      return CNT_W'((1 << vlmul) - 1);
   endfunction

endpackage

// File: rtl/riscv_v_wb_seq_byte_en.sv
// Per-byte write-enable generation for one destination register of a group.
// With RISCV_V_WB_VTA_EN defined, tail bytes are force-written as 0xFF when vta=1.
module riscv_v_wb_seq_byte_en
   import riscv_v_wb_seq_pkg::*;
(
   input  logic [CNT_W-1:0]     r,
   input  logic [1:0]           vsew,
   input  logic [VL_W-1:0]      vl,
   input  logic [VL_W-1:0]      vstart,
   input  logic [NUM_BYTES-1:0] byte_en,
   input  logic                 vta,
   output logic [NUM_BYTES-1:0] wr_en,
   output logic [NUM_BYTES-1:0] tail_fill
);

`ifndef RISCV_V_WB_VTA_EN
   logic unused_vta;
   assign unused_vta = vta;
`endif

   always_comb begin
      logic [VL_W-1:0] pos;
      logic [VL_W-1:0] elem;
      logic            in_tail;
      logic            in_body;
      wr_en     = '0;
      tail_fill = '0;
      pos       = '0;
      elem      = '0;
      in_tail   = 1'b0;
      in_body   = 1'b0;
      for (int b = 0; b < NUM_BYTES; b++) begin
         // Byte offset within the whole group, then scaled down to an element index.
         pos     = VL_W'({r, BYTE_IDX_W'(b)});
         elem    = pos >> vsew;
         in_tail = (elem >= vl);
         in_body = (elem >= vstart) && !in_tail;
         wr_en[b] = byte_en[b] && in_body;
`ifdef RISCV_V_WB_VTA_EN
         if (vta && in_tail) begin
            wr_en[b]     = 1'b1;
            tail_fill[b] = 1'b1;
         end
`endif
      end
   end

endmodule

// File: rtl/riscv_v_wb_seq.sv
// Vector register-file write sequencer: one command, then one data beat per register.
// Optional tail-agnostic fill is controlled by the RISCV_V_WB_VTA_EN macro.
module riscv_v_wb_seq
   import riscv_v_wb_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [ADDR_W-1:0]    cmd_vd,
   input  logic [1:0]           cmd_vlmul,
   input  logic [1:0]           cmd_vsew,
   input  logic [VL_W-1:0]      cmd_vl,
   input  logic [VL_W-1:0]      cmd_vstart,
   input  logic                 cmd_vta,
   input  logic                 beat_valid,
   output logic                 beat_ready,
   input  logic [DATA_W-1:0]    beat_data,
   input  logic [NUM_BYTES-1:0] beat_byte_en,
   output logic [ADDR_W-1:0]    rf_wr_addr,
   output logic [DATA_W-1:0]    rf_wr_data,
   output logic [NUM_BYTES-1:0] rf_wr_en,
   output logic                 done
);

   // Handshake: a transfer happens on a rising edge where valid && ready; ready never
   // depends on valid, and both readys drop whenever stall or flush is high.

   riscv_v_wb_state_e state, state_nxt;

   logic [CNT_W-1:0]     r_q;
   logic [CNT_W-1:0]     last_q;
   logic [ADDR_W-1:0]    vd_q;
   logic [1:0]           vsew_q;
   logic [VL_W-1:0]      vl_q;
   logic [VL_W-1:0]      vstart_q;
   logic                 vta_q;

   logic                 cmd_acc;
   logic                 beat_acc;
   logic                 last_acc;
   logic [NUM_BYTES-1:0] be_en;
   logic [NUM_BYTES-1:0] tail_fill;
   logic [DATA_W-1:0]    fill_data;

   assign cmd_ready  = (state == IDLE)   && !stall && !flush;
   assign beat_ready = (state == ACTIVE) && !stall && !flush;
   assign cmd_acc    = cmd_valid  && cmd_ready;
   assign beat_acc   = beat_valid && beat_ready;
   assign last_acc   = beat_acc && (r_q == last_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cmd_acc) state_nxt = ACTIVE;
         end
         ACTIVE: begin
            if (flush)         state_nxt = IDLE;
            else if (last_acc) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   riscv_v_wb_seq_byte_en u_byte_en (
      .r         (r_q),
      .vsew      (vsew_q),
      .vl        (vl_q),
      .vstart    (vstart_q),
      .byte_en   (beat_byte_en),
      .vta       (vta_q),
      .wr_en     (be_en),
      .tail_fill (tail_fill)
   );

   always_comb begin
      fill_data = beat_data;
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (tail_fill[b]) fill_data[b*8 +: 8] = 8'hFF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q        <= '0;
         last_q     <= '0;
         vd_q       <= '0;
         vsew_q     <= '0;
         vl_q       <= '0;
         vstart_q   <= '0;
         vta_q      <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
         rf_wr_en   <= '0;
         done       <= 1'b0;
      end else begin
         if (cmd_acc) begin
            vd_q     <= cmd_vd;
            vsew_q   <= cmd_vsew;
            vl_q     <= cmd_vl;
            vstart_q <= cmd_vstart;
            vta_q    <= cmd_vta;
            last_q   <= last_beat(cmd_vlmul);
            r_q      <= '0;
         end else if (flush) begin
            r_q <= '0;
         end else if (beat_acc) begin
            r_q <= last_acc ? '0 : r_q + 1'b1;
         end

         // Address and data hold between writes; only the enables fall back to zero.
         if (beat_acc) begin
            rf_wr_addr <= vd_q + ADDR_W'(r_q);
            rf_wr_data <= fill_data;
         end
         rf_wr_en <= beat_acc ? be_en : '0;
         done     <= last_acc;
      end
   end

endmodule

// File: tb/tb_riscv_v_wb_seq.sv
// Self-checking bench for riscv_v_wb_seq: directed scenarios plus randomized groups
// checked against an element-level model of the body/prestart/tail rules.
module tb_riscv_v_wb_seq;
   import riscv_v_wb_seq_pkg::*;

`ifdef RISCV_V_WB_VTA_EN
   localparam bit VTA_ON = 1'b1;
`else
   localparam bit VTA_ON = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 stall;
   logic                 flush;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [ADDR_W-1:0]    cmd_vd;
   logic [1:0]           cmd_vlmul;
   logic [1:0]           cmd_vsew;
   logic [VL_W-1:0]      cmd_vl;
   logic [VL_W-1:0]      cmd_vstart;
   logic                 cmd_vta;
   logic                 beat_valid;
   logic                 beat_ready;
   logic [DATA_W-1:0]    beat_data;
   logic [NUM_BYTES-1:0] beat_byte_en;
   logic [ADDR_W-1:0]    rf_wr_addr;
   logic [DATA_W-1:0]    rf_wr_data;
   logic [NUM_BYTES-1:0] rf_wr_en;
   logic                 done;

   int checks   = 0;
   int failures = 0;
   int last_cmd_wait;

   logic [NUM_BYTES-1:0] exp_q[$];
   logic [ADDR_W-1:0]    obs_addr[8];
   logic [NUM_BYTES-1:0] obs_en[8];
   logic [DATA_W-1:0]    obs_data[8];
   logic [DATA_W-1:0]    obs_beat[8];
   logic                 obs_done[8];

   riscv_v_wb_seq dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_vd       (cmd_vd),
      .cmd_vlmul    (cmd_vlmul),
      .cmd_vsew     (cmd_vsew),
      .cmd_vl       (cmd_vl),
      .cmd_vstart   (cmd_vstart),
      .cmd_vta      (cmd_vta),
      .beat_valid   (beat_valid),
      .beat_ready   (beat_ready),
      .beat_data    (beat_data),
      .beat_byte_en (beat_byte_en),
      .rf_wr_addr   (rf_wr_addr),
      .rf_wr_data   (rf_wr_data),
      .rf_wr_en     (rf_wr_en),
      .done         (done)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Reference model: element index of every byte from plain arithmetic.
   function automatic void model_beat(input int vsew, input int vl, input int vstart,
                                      input bit vta, input int r,
                                      input logic [NUM_BYTES-1:0] be,
                                      input logic [DATA_W-1:0] din,
                                      output logic [NUM_BYTES-1:0] en,
                                      output logic [DATA_W-1:0] dout);
      en   = '0;
      dout = din;
      for (int b = 0; b < NUM_BYTES; b++) begin
         int elem;
         elem = (r * NUM_BYTES + b) / (1 << vsew);
         if (be[b] && elem >= vstart && elem < vl) en[b] = 1'b1;
         if (VTA_ON && vta && elem >= vl) begin
            en[b] = 1'b1;
            dout[b*8 +: 8] = 8'hFF;
         end
      end
   endfunction

   // Driver tasks
   task automatic send_cmd(input int vd, input int vlmul, input int vsew,
                           input int vl, input int vstart, input bit vta);
      int n;
      n = 0;
      cmd_valid  = 1'b1;
      cmd_vd     = ADDR_W'(vd);
      cmd_vlmul  = 2'(vlmul);
      cmd_vsew   = 2'(vsew);
      cmd_vl     = VL_W'(vl);
      cmd_vstart = VL_W'(vstart);
      cmd_vta    = vta;
      #1;
      while (!cmd_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      last_cmd_wait = n;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL cmd_timeout: cmd_ready=%b expected 1", cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      checks++;
      if (rf_wr_en !== '0 || done !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_cmd: en=%h done=%b expected en=0 done=0", rf_wr_en, done);
      end
   endtask

   task automatic send_beat(input int r, input int vd, input int vsew, input int vl,
                            input int vstart, input bit vta, input bit last,
                            input int stall_cycles, input bit rand_be,
                            input logic [NUM_BYTES-1:0] be_fixed);
      logic [NUM_BYTES-1:0] be, exp_en, got_en;
      logic [DATA_W-1:0]    data, exp_data;
      logic [ADDR_W-1:0]    exp_addr;
      int n;
      be   = rand_be ? NUM_BYTES'($urandom) : be_fixed;
      data = {$urandom, $urandom, $urandom, $urandom};
      model_beat(vsew, vl, vstart, vta, r, be, data, exp_en, exp_data);
      exp_q.push_back(exp_en);
      exp_addr = ADDR_W'((vd + r) % 32);
      beat_valid   = 1'b1;
      beat_data    = data;
      beat_byte_en = be;
      for (int k = 0; k < stall_cycles; k++) begin
         stall = 1'b1;
         #1;
         checks++;
         if (beat_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_ready: beat_ready=%b expected 0", beat_ready);
         end
         @(posedge clk); #1;
         checks++;
         if (rf_wr_en !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL stall_write: en=%h done=%b expected en=0 done=0", rf_wr_en, done);
         end
      end
      stall = 1'b0;
      #1;
      n = 0;
      while (!beat_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (beat_ready !== 1'b1) begin
         failures++;
         $display("FAIL beat_timeout: beat_ready=%b expected 1", beat_ready);
      end
      @(posedge clk); #1;
      beat_valid = 1'b0;
      got_en = exp_q.pop_front();
      obs_addr[r] = rf_wr_addr;
      obs_en[r]   = rf_wr_en;
      obs_data[r] = rf_wr_data;
      obs_beat[r] = data;
      obs_done[r] = done;
      checks++;
      if (rf_wr_en !== got_en) begin
         failures++;
         $display("FAIL wr_en: beat %0d got %h expected %h", r, rf_wr_en, got_en);
      end
      checks++;
      if (rf_wr_addr !== exp_addr) begin
         failures++;
         $display("FAIL wr_addr: beat %0d got %0d expected %0d", r, rf_wr_addr, exp_addr);
      end
      checks++;
      if (rf_wr_data !== exp_data) begin
         failures++;
         $display("FAIL wr_data: beat %0d got %h expected %h", r, rf_wr_data, exp_data);
      end
      checks++;
      if (done !== last) begin
         failures++;
         $display("FAIL done: beat %0d got %b expected %b", r, done, last);
      end
   endtask

   task automatic do_group(input int vd, input int vlmul, input int vsew, input int vl,
                           input int vstart, input bit vta, input int stall_cycles,
                           input bit rand_be, input logic [NUM_BYTES-1:0] be_fixed);
      int nb;
      nb = 1 << vlmul;
      send_cmd(vd, vlmul, vsew, vl, vstart, vta);
      for (int r = 0; r < nb; r++) begin
         send_beat(r, vd, vsew, vl, vstart, vta, (r == nb - 1), stall_cycles, rand_be, be_fixed);
      end
   endtask

   // Scenario tasks
   task automatic test_reset();
      rst = 1'b1;
      stall = 1'b0; flush = 1'b0; cmd_valid = 1'b0; beat_valid = 1'b0;
      cmd_vd = '0; cmd_vlmul = '0; cmd_vsew = '0; cmd_vl = '0; cmd_vstart = '0; cmd_vta = 1'b0;
      beat_data = '0; beat_byte_en = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (rf_wr_en !== '0 || rf_wr_addr !== '0 || rf_wr_data !== '0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: en=%h addr=%0d done=%b expected all 0", rf_wr_en, rf_wr_addr, done);
      end
      checks++;
      if (cmd_ready !== 1'b1 || beat_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready: cmd_ready=%b beat_ready=%b expected 1 0", cmd_ready, beat_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_group(4, 0, 0, 10, 0, 1'b0, 0, 1'b0, 16'hFFFF);
      checks++;
      if (obs_addr[0] !== 5'd4 || obs_en[0] !== 16'h03FF || obs_done[0] !== 1'b1) begin
         failures++;
         $display("FAIL single: addr=%0d en=%h done=%b expected 4 03ff 1", obs_addr[0], obs_en[0], obs_done[0]);
      end
   endtask

   task automatic test_wrap();
      logic [ADDR_W-1:0]    ea[4];
      logic [NUM_BYTES-1:0] ee[4];
      ea = '{5'd30, 5'd31, 5'd0, 5'd1};
      ee = '{16'hFF00, 16'hFFFF, 16'hFFFF, 16'h000F};
      do_group(30, 2, 2, 13, 2, 1'b0, 0, 1'b0, 16'hFFFF);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (obs_addr[i] !== ea[i] || obs_en[i] !== ee[i] || obs_done[i] !== (i == 3)) begin
            failures++;
            $display("FAIL wrap: beat %0d got addr=%0d en=%h done=%b expected %0d %h %b",
                     i, obs_addr[i], obs_en[i], obs_done[i], ea[i], ee[i], (i == 3));
         end
      end
   endtask

   task automatic test_empty();
      do_group(7, 0, 0, 5, 7, 1'b0, 0, 1'b0, 16'hFFFF);
      checks++;
      if (obs_en[0] !== 16'h0000 || obs_done[0] !== 1'b1) begin
         failures++;
         $display("FAIL empty: en=%h done=%b expected 0000 1", obs_en[0], obs_done[0]);
      end
   endtask

   task automatic test_stall();
      do_group(10, 1, 0, 128, 0, 1'b0, 3, 1'b0, 16'hFFFF);
      checks++;
      if (obs_addr[1] !== 5'd11 || obs_en[1] !== 16'hFFFF || obs_done[1] !== 1'b1) begin
         failures++;
         $display("FAIL stall_group: addr=%0d en=%h done=%b expected 11 ffff 1", obs_addr[1], obs_en[1], obs_done[1]);
      end
   endtask

   task automatic test_flush();
      send_cmd(12, 3, 0, 128, 0, 1'b0);
      send_beat(0, 12, 0, 128, 0, 1'b0, 1'b0, 0, 1'b1, '0);
      flush = 1'b1;
      beat_valid = 1'b1;
      #1;
      checks++;
      if (beat_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_ready: beat_ready=%b expected 0", beat_ready);
      end
      @(posedge clk); #1;
      beat_valid = 1'b0;
      checks++;
      if (rf_wr_en !== '0 || done !== 1'b0) begin
         failures++;
         $display("FAIL flush_write: en=%h done=%b expected 0 0", rf_wr_en, done);
      end
      // Flush while idle with a pending command must not accept it.
      cmd_valid = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_cmd: cmd_ready=%b expected 0", cmd_ready);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      cmd_valid = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_to_idle: cmd_ready=%b expected 1", cmd_ready);
      end
      do_group(12, 1, 1, 100, 0, 1'b0, 0, 1'b0, 16'hFFFF);
      checks++;
      if (obs_addr[0] !== 5'd12 || obs_addr[1] !== 5'd13) begin
         failures++;
         $display("FAIL flush_restart: addr0=%0d addr1=%0d expected 12 13", obs_addr[0], obs_addr[1]);
      end
   endtask

   task automatic test_reset_mid();
      send_cmd(0, 3, 0, 128, 0, 1'b0);
      send_beat(0, 0, 0, 128, 0, 1'b0, 1'b0, 0, 1'b0, 16'hFFFF);
      beat_valid = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (rf_wr_en !== '0 || done !== 1'b0 || rf_wr_addr !== '0 || rf_wr_data !== '0) begin
         failures++;
         $display("FAIL reset_mid_out: en=%h done=%b addr=%0d expected all 0", rf_wr_en, done, rf_wr_addr);
      end
      checks++;
      if (cmd_ready !== 1'b1 || beat_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_state: cmd_ready=%b beat_ready=%b expected 1 0", cmd_ready, beat_ready);
      end
      beat_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      do_group(9, 0, 0, 16, 0, 1'b0, 0, 1'b0, 16'hFFFF);
      checks++;
      if (obs_addr[0] !== 5'd9 || obs_done[0] !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_restart: addr=%0d done=%b expected 9 1", obs_addr[0], obs_done[0]);
      end
   endtask

   task automatic test_vta();
      logic [NUM_BYTES-1:0] exp_en;
      logic [DATA_W-32-1:0] exp_hi;
      do_group(3, 0, 0, 4, 0, 1'b1, 0, 1'b0, 16'h000F);
      exp_en = VTA_ON ? 16'hFFFF : 16'h000F;
      exp_hi = VTA_ON ? {(DATA_W-32){1'b1}} : obs_beat[0][DATA_W-1:32];
      checks++;
      if (obs_en[0] !== exp_en) begin
         failures++;
         $display("FAIL vta_en: got %h expected %h", obs_en[0], exp_en);
      end
      checks++;
      if (obs_data[0][DATA_W-1:32] !== exp_hi) begin
         failures++;
         $display("FAIL vta_data: got %h expected %h", obs_data[0][DATA_W-1:32], exp_hi);
      end
   endtask

   task automatic test_back_to_back();
      do_group(16, 1, 3, 3, 1, 1'b0, 0, 1'b1, '0);
      do_group(18, 0, 1, 8, 0, 1'b0, 0, 1'b1, '0);
      checks++;
      if (last_cmd_wait != 0) begin
         failures++;
         $display("FAIL back_to_back_gap: waited %0d cycles expected 0", last_cmd_wait);
      end
   endtask

   task automatic test_random();
      for (int g = 0; g < 30; g++) begin
         int vl;
         vl = $urandom_range(0, 128);
         do_group($urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 3), vl,
                  $urandom_range(0, vl + 4), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), 1'b1, '0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_empty();
      test_stall();
      test_flush();
      test_reset_mid();
      test_vta();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
